// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generation stage.
package pc_gen_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] EXC_VECTOR_DEF   = 32'h0000_0080;

    typedef enum logic [1:0] {
        PC_RUN       = 2'd0,
        PC_MISS      = 2'd1,
        PC_MISS_PEND = 2'd2
    } pc_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the hazard/branch logic, the ROM and the PC generator.
interface pc_gen_if;

    logic                         Stall;
    logic                         Imiss;
    logic                         Redirect;
    logic [pc_gen_pkg::XLEN-1:0]  RedirectTarget;
    logic                         Exception;
    logic [pc_gen_pkg::XLEN-1:0]  InstrAddr;
    logic [pc_gen_pkg::XLEN-1:0]  PcPlus4;
    logic                         FetchValid;
    logic                         Misaligned;

    modport master (
        output Stall, Imiss, Redirect, RedirectTarget, Exception,
        input  InstrAddr, PcPlus4, FetchValid, Misaligned
    );

    modport slave (
        input  Stall, Imiss, Redirect, RedirectTarget, Exception,
        output InstrAddr, PcPlus4, FetchValid, Misaligned
    );

endinterface

// File: rtl/pc_gen_redirect_buf.sv
// Holds a redirect/exception target that arrived while the ROM was missing.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            clear,
    input  logic            capture,
    input  logic            exception,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pend_target
);

    logic valid;
    logic is_exc;

    // An exception target is sticky: only a newer exception may replace it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid       <= 1'b0;
            is_exc      <= 1'b0;
            pend_target <= '0;
        end else if (clear) begin
            valid  <= 1'b0;
            is_exc <= 1'b0;
        end else if (capture) begin
            if (exception) begin
                valid       <= 1'b1;
                is_exc      <= 1'b1;
                pend_target <= EXC_VECTOR;
            end else if (redirect && !(valid && is_exc)) begin
                valid       <= 1'b1;
                is_exc      <= 1'b0;
                pend_target <= redirect_target;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: registered fetch address, redirect/exception vectoring, miss hold.
//   state        | meaning
//   PC_RUN       | fetching; PC advances, redirects or stalls
//   PC_MISS      | ROM miss outstanding, nothing pending
//   PC_MISS_PEND | ROM miss outstanding, target buffered for release
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [XLEN-1:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input  logic     Clk,
    input  logic     Rst,
    pc_gen_if.slave  bus
);

    pc_state_t       state, nxt_state;
    logic [XLEN-1:0] pc_q, pc_plus4_q, nxt_pc, tgt, pend_target;
    logic            mis_q, nxt_mis;
    logic            apply, capture, clear;
    logic            redirect_req;

    assign redirect_req = bus.Exception || bus.Redirect;

    pc_redirect_buf #(.EXC_VECTOR(EXC_VECTOR)) u_buf (
        .Clk             (Clk),
        .Rst             (Rst),
        .clear           (clear),
        .capture         (capture),
        .exception       (bus.Exception),
        .redirect        (bus.Redirect),
        .redirect_target (bus.RedirectTarget),
        .pend_target     (pend_target)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= PC_RUN;
            pc_q       <= RESET_VECTOR;
            pc_plus4_q <= RESET_VECTOR + XLEN'(INSTR_BYTES);
            mis_q      <= 1'b0;
        end else begin
            state      <= nxt_state;
            pc_q       <= nxt_pc;
            pc_plus4_q <= nxt_pc + XLEN'(INSTR_BYTES);
            mis_q      <= nxt_mis;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_pc    = pc_q;
        nxt_mis   = mis_q;
        capture   = 1'b0;
        clear     = 1'b0;
        apply     = 1'b0;
        tgt       = '0;
        unique case (state)
            PC_RUN, PC_MISS: begin
                if (bus.Imiss) begin
                    capture   = redirect_req;
                    nxt_state = redirect_req ? PC_MISS_PEND : PC_MISS;
                end else begin
                    nxt_state = PC_RUN;
                    if (bus.Exception) begin
                        apply = 1'b1;
                        tgt   = EXC_VECTOR;
                    end else if (bus.Redirect) begin
                        apply = 1'b1;
                        tgt   = bus.RedirectTarget;
                    end else if (!bus.Stall) begin
                        nxt_pc = pc_q + XLEN'(INSTR_BYTES);
                    end
                end
            end
            PC_MISS_PEND: begin
                if (bus.Imiss) begin
                    capture = redirect_req;
                end else begin
                    // Release ignores Stall/Redirect; a fresh exception still wins.
                    apply     = 1'b1;
                    clear     = 1'b1;
                    tgt       = bus.Exception ? EXC_VECTOR : pend_target;
                    nxt_state = PC_RUN;
                end
            end
            default: nxt_state = PC_RUN;
        endcase
        if (apply) begin
            nxt_pc  = word_align(tgt);
            nxt_mis = (tgt[1:0] != 2'b00);
        end
    end

    assign bus.InstrAddr  = pc_q;
    assign bus.PcPlus4    = pc_plus4_q;
    assign bus.Misaligned = mis_q;
    assign bus.FetchValid = !Rst && (state == PC_RUN) && !bus.Imiss;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen.
module tb_pc_gen;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pc_gen_if bus ();

    pc_gen dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Stall          = 1'b0;
        bus.Imiss          = 1'b0;
        bus.Redirect       = 1'b0;
        bus.RedirectTarget = 32'h0;
        bus.Exception      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Rst = 1'b1;
        step();
        Rst = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        bus.Redirect       = 1'b1;
        bus.RedirectTarget = t;
    endtask

    task automatic test_reset();
        idle_inputs();
        Rst = 1'b1;
        #1;
        checks++;
        if (bus.FetchValid !== 1'b0) begin errors++; $display("FAIL fv_in_reset got %b exp 0", bus.FetchValid); end
        step();
        checks++;
        if (bus.InstrAddr !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 00000000", bus.InstrAddr); end
        checks++;
        if (bus.PcPlus4 !== 32'h4) begin errors++; $display("FAIL reset_plus4 got %h exp 00000004", bus.PcPlus4); end
        checks++;
        if (bus.Misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got %b exp 0", bus.Misaligned); end
        Rst = 1'b0;
        #1;
        checks++;
        if (bus.FetchValid !== 1'b1) begin errors++; $display("FAIL fv_after_reset got %b exp 1", bus.FetchValid); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC; exp_pc[3] = 32'h10;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.InstrAddr !== exp_pc[i]) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, bus.InstrAddr, exp_pc[i]); end
            checks++;
            if (bus.PcPlus4 !== exp_pc[i] + 32'h4) begin errors++; $display("FAIL seq_plus4[%0d] got %h exp %h", i, bus.PcPlus4, exp_pc[i] + 32'h4); end
            checks++;
            if (bus.FetchValid !== 1'b1) begin errors++; $display("FAIL seq_fv[%0d] got %b exp 1", i, bus.FetchValid); end
        end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        step(); step();
        redirect_to(32'h100);
        bus.Stall = 1'b1;
        step();
        checks++;
        if (bus.InstrAddr !== 32'h100) begin errors++; $display("FAIL redir_over_stall got %h exp 00000100", bus.InstrAddr); end
        idle_inputs();
        step();
        checks++;
        if (bus.InstrAddr !== 32'h104) begin errors++; $display("FAIL after_redir got %h exp 00000104", bus.InstrAddr); end
        bus.Stall = 1'b1;
        step(); step();
        checks++;
        if (bus.InstrAddr !== 32'h104) begin errors++; $display("FAIL stall_hold got %h exp 00000104", bus.InstrAddr); end
        checks++;
        if (bus.PcPlus4 !== 32'h108) begin errors++; $display("FAIL stall_plus4 got %h exp 00000108", bus.PcPlus4); end
        idle_inputs();
    endtask

    task automatic test_miss_redirect();
        do_reset();
        step(); step(); step();
        bus.Imiss = 1'b1;
        #1;
        checks++;
        if (bus.FetchValid !== 1'b0) begin errors++; $display("FAIL fv_miss got %b exp 0", bus.FetchValid); end
        step();
        redirect_to(32'h200);
        step();
        bus.Redirect = 1'b0;
        step();
        checks++;
        if (bus.InstrAddr !== 32'hC) begin errors++; $display("FAIL miss_hold got %h exp 0000000c", bus.InstrAddr); end
        bus.Imiss = 1'b0;
        #1;
        checks++;
        if (bus.FetchValid !== 1'b0) begin errors++; $display("FAIL fv_miss_pend got %b exp 0", bus.FetchValid); end
        step();
        checks++;
        if (bus.InstrAddr !== 32'h200) begin errors++; $display("FAIL miss_release got %h exp 00000200", bus.InstrAddr); end
        checks++;
        if (bus.FetchValid !== 1'b1) begin errors++; $display("FAIL fv_release got %b exp 1", bus.FetchValid); end
        step();
        checks++;
        if (bus.InstrAddr !== 32'h204) begin errors++; $display("FAIL post_release got %h exp 00000204", bus.InstrAddr); end
    endtask

    task automatic test_miss_exception();
        do_reset();
        bus.Imiss = 1'b1;
        redirect_to(32'h300);
        step();
        bus.Redirect  = 1'b0;
        bus.Exception = 1'b1;
        step();
        bus.Exception = 1'b0;
        redirect_to(32'h400);
        step();
        checks++;
        if (bus.InstrAddr !== 32'h0) begin errors++; $display("FAIL exc_pend_hold got %h exp 00000000", bus.InstrAddr); end
        idle_inputs();
        step();
        checks++;
        if (bus.InstrAddr !== 32'h80) begin errors++; $display("FAIL exc_release got %h exp 00000080", bus.InstrAddr); end
        checks++;
        if (bus.PcPlus4 !== 32'h84) begin errors++; $display("FAIL exc_plus4 got %h exp 00000084", bus.PcPlus4); end
        // Release ignores a concurrent Redirect and Stall
        do_reset();
        bus.Imiss = 1'b1;
        redirect_to(32'h300);
        step();
        bus.Imiss = 1'b0;
        bus.Stall = 1'b1;
        redirect_to(32'h500);
        step();
        checks++;
        if (bus.InstrAddr !== 32'h300) begin errors++; $display("FAIL release_ignores_redir got %h exp 00000300", bus.InstrAddr); end
        // Exception at release beats the pending redirect
        do_reset();
        bus.Imiss = 1'b1;
        redirect_to(32'h300);
        step();
        idle_inputs();
        bus.Exception = 1'b1;
        step();
        checks++;
        if (bus.InstrAddr !== 32'h80) begin errors++; $display("FAIL release_exc_wins got %h exp 00000080", bus.InstrAddr); end
        idle_inputs();
    endtask

    task automatic test_misaligned();
        do_reset();
        redirect_to(32'h103);
        step();
        checks++;
        if (bus.InstrAddr !== 32'h100) begin errors++; $display("FAIL mis_pc got %h exp 00000100", bus.InstrAddr); end
        checks++;
        if (bus.Misaligned !== 1'b1) begin errors++; $display("FAIL mis_set got %b exp 1", bus.Misaligned); end
        idle_inputs();
        step();
        checks++;
        if (bus.Misaligned !== 1'b1) begin errors++; $display("FAIL mis_sticky got %b exp 1", bus.Misaligned); end
        redirect_to(32'h40);
        step();
        checks++;
        if (bus.InstrAddr !== 32'h40) begin errors++; $display("FAIL mis_clr_pc got %h exp 00000040", bus.InstrAddr); end
        checks++;
        if (bus.Misaligned !== 1'b0) begin errors++; $display("FAIL mis_clr got %b exp 0", bus.Misaligned); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_miss_and_wrap();
        do_reset();
        step();
        bus.Imiss = 1'b1;
        redirect_to(32'h300);
        step();
        idle_inputs();
        bus.Imiss = 1'b1;
        Rst = 1'b1;
        step();
        checks++;
        if (bus.InstrAddr !== 32'h0) begin errors++; $display("FAIL rst_miss_pc got %h exp 00000000", bus.InstrAddr); end
        Rst = 1'b0;
        bus.Imiss = 1'b0;
        #1;
        checks++;
        if (bus.FetchValid !== 1'b1) begin errors++; $display("FAIL rst_miss_run got %b exp 1", bus.FetchValid); end
        step();
        checks++;
        if (bus.InstrAddr !== 32'h4) begin errors++; $display("FAIL rst_pend_dropped got %h exp 00000004", bus.InstrAddr); end
        redirect_to(32'hFFFF_FFFC);
        step();
        checks++;
        if (bus.PcPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h exp 00000000", bus.PcPlus4); end
        idle_inputs();
        step();
        checks++;
        if (bus.InstrAddr !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 00000000", bus.InstrAddr); end
        checks++;
        if (bus.PcPlus4 !== 32'h4) begin errors++; $display("FAIL wrap_next_plus4 got %h exp 00000004", bus.PcPlus4); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_stall();
        test_miss_redirect();
        test_miss_exception();
        test_misaligned();
        test_reset_mid_miss_and_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
